// File: rtl/sram_fill_verify.sv
// sram_fill_verify: built-in self-test controller for an external async SRAM.
// On start, it writes pat(a) = a ^ key to addresses 0..last_addr. It then reads
// every word back and compares it against the same pattern. Results are a pass
// flag, a saturating mismatch count and the first failing address. All SRAM pin
// outputs are registered, so the bus carries no decode glitches.
module sram_fill_verify #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              ub_n,
  output logic              lb_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_STROBE,
    S_TURN,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr, addr_nx;
  logic [ADDR_W-1:0]   last_q;
  logic [DATA_W-1:0]   key_q, key_sel;
  logic [DATA_W-1:0]   dq_out;
  logic                dq_oe;
  logic                accept;
  logic                cmp_valid;
  logic [ADDR_W-1:0]   cmp_addr;
  logic                mismatch;
  logic [ERR_W-1:0]    err_nx;
  logic [ADDR_W-1:0]   first_nx;
  logic                pass_nx;

  // The test pattern: the address is zero-extended or truncated to the data width, then XORed with the key.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] k);
    return DATA_W'(a) ^ k;
  endfunction

  // Both byte lanes are enabled for the whole test.
  assign ub_n = 1'b0;
  assign lb_n = 1'b0;

  // The address counter drives the SRAM address pins directly, so the pins are registered.
  assign sram_addr = addr;

  // The controller drives the data bus only during write cycles. Reset clears dq_oe, so the bus floats at once.
  assign sram_dq = dq_oe ? dq_out : 'z;

  // Next-state and address sequencing. The end of a pass is detected by comparing the counter with last_q, never by counter carry.
  always_comb begin
    // NOTE: every signal gets a default before the case statement; a path with no assignment would infer a latch.
    state_nx = state;
    addr_nx  = addr;
    accept   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_W_SETUP;
          addr_nx  = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_W_SETUP:  state_nx = S_W_STROBE;
      S_W_STROBE: begin
        if (addr == last_q) begin
          state_nx = S_TURN;
          addr_nx  = '0;
        end else begin
          state_nx = S_W_SETUP;
          addr_nx  = addr + ADDR_W'(1);
        end
      end
      S_TURN:     state_nx = S_READ;
      S_READ: begin
        if (addr == last_q) begin
          state_nx = S_DRAIN;
        end else begin
          addr_nx  = addr + ADDR_W'(1);
        end
      end
      S_DRAIN:    state_nx = S_DONE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Result bookkeeping. A run that is starting clears the results; a sample that mismatches updates them.
  always_comb begin
    key_sel  = accept ? key : key_q;
    mismatch = cmp_valid && (sram_dq != pat(cmp_addr, key_q));
    err_nx   = err_count;
    first_nx = first_err_addr;
    pass_nx  = pass;
    if (accept) begin
      err_nx   = '0;
      first_nx = '0;
      pass_nx  = 1'b0;
    end else begin
      if (mismatch && err_count == '0) begin
        first_nx = cmp_addr;
      end
      if (mismatch && err_count != '1) begin
        err_nx = err_count + ERR_W'(1);
      end
      // The last word is compared on the DRAIN edge, so pass must include that final comparison.
      if (state == S_DRAIN) begin
        pass_nx = (err_nx == '0);
      end
    end
  end

  // State, counters, latched parameters and registered pin controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      last_q         <= '0;
      key_q          <= '0;
      dq_out         <= '0;
      dq_oe          <= 1'b0;
      we_n           <= 1'b1;
      oe_n           <= 1'b1;
      ce_n           <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
      state          <= state_nx;
      addr           <= addr_nx;
      if (accept) begin
        last_q <= last_addr;
        key_q  <= key;
      end
      dq_out         <= pat(addr_nx, key_sel);
      dq_oe          <= (state_nx == S_W_SETUP) || (state_nx == S_W_STROBE);
      we_n           <= (state_nx != S_W_STROBE);
      oe_n           <= !((state_nx == S_READ) || (state_nx == S_DRAIN));
      busy           <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      ce_n           <= (state_nx == S_IDLE) || (state_nx == S_DONE);
      done           <= (state_nx == S_DONE);
      pass           <= pass_nx;
      err_count      <= err_nx;
      first_err_addr <= first_nx;
      // With one cycle of read latency, the data for the address presented in this READ cycle arrives in the next cycle.
      cmp_valid      <= (state == S_READ);
      cmp_addr       <= addr;
    end
  end

endmodule

// File: tb/tb_sram_fill_verify.sv
// tb_sram_fill_verify: directed bench for sram_fill_verify with a 16-word SRAM
// model that has one cycle of read latency and optional read-fault injection.
module tb_sram_fill_verify;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int ERR_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] key = '0;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr, sram_addr;
  wire  [DATA_W-1:0] sram_dq;
  logic              ce_n, oe_n, we_n, ub_n, lb_n;

  int n_checks = 0;
  int n_errors = 0;

  // Fault modes: 0 = ideal, 1 = flip bit 0 when reading address 5, 2 = invert every read.
  int                fault = 0;
  logic [DATA_W-1:0] mem [16];
  logic [DATA_W-1:0] rd_q;

  always #5 clk = ~clk;

  sram_fill_verify #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .last_addr(last_addr), .key(key),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .ub_n(ub_n), .lb_n(lb_n)
  );

  // SRAM model: writes on a clock edge during a we_n strobe; read data follows the sampled address by one cycle.
  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;
    case (fault)
      1:       rd_q <= mem[sram_addr] ^ {15'b0, (sram_addr == 4'd5)};
      2:       rd_q <= ~mem[sram_addr];
      default: rd_q <= mem[sram_addr];
    endcase
  end
  assign sram_dq = (!ce_n && !oe_n) ? rd_q : 'z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulses start for a single edge (edge 0). The task is called 1 time unit after an edge and returns 1 time unit after edge 0.
  task automatic start_run(input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] k);
    last_addr = la;
    key       = k;
    start     = 1'b1;
    @(posedge clk);
    #1 start  = 1'b0;
  endtask

  // Waits for the done pulse and returns the number of the edge after which done became high. Returns -1 on timeout.
  task automatic wait_done(input int base, output int edge_no);
    edge_no = -1;
    for (int k = base + 1; k <= base + 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edge_no = k;
        return;
      end
    end
  endtask

  initial begin
    int e;
    // Reset the DUT and check the idle state of every output.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_ce_n", ce_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_ub_lb", {ub_n, lb_n}, 0);
    check("rst_dq_z", (sram_dq === 16'bz), 1);

    // Test 1: assert reset in the middle of a write strobe.
    start_run(4'd15, 16'hA5A5);
    check("t1_busy", busy, 1);
    e = 0;
    for (int k = 0; k < 20 && !(we_n === 1'b0); k++) begin
      @(posedge clk);
      #1 e = k;
    end
    check("t1_saw_strobe", we_n, 0);
    #2 rst = 1'b0;
    #1;
    check("t1_we_n", we_n, 1);
    check("t1_dq_z", (sram_dq === 16'bz), 1);
    check("t1_ctrl", {ce_n, oe_n, busy, done, pass}, 5'b11000);
    check("t1_err", err_count, 0);
    check("t1_first", first_err_addr, 0);
    check("t1_addr", sram_addr, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Test 2: full range with an ideal SRAM. Inputs change during the run and must be ignored.
    fault = 0;
    start_run(4'd15, 16'hA5A5);
    last_addr = 4'd3;
    key       = 16'h0000;
    wait_done(0, e);
    check("t2_latency", e, 50);
    check("t2_pass", pass, 1);
    check("t2_err", err_count, 0);
    check("t2_first", first_err_addr, 0);
    check("t2_busy_done", busy, 0);
    for (int a = 0; a < 16; a++) check($sformatf("t2_mem%0d", a), mem[a], a ^ 16'hA5A5);
    @(posedge clk);
    #1;
    check("t2_done_pulse", done, 0);
    check("t2_pass_held", pass, 1);
    check("t2_bus_idle", {ce_n, oe_n, we_n}, 3'b111);

    // Test 3: a single-bit read fault at address 5.
    fault = 1;
    start_run(4'd15, 16'hA5A5);
    wait_done(0, e);
    check("t3_latency", e, 50);
    check("t3_err", err_count, 1);
    check("t3_first", first_err_addr, 5);
    check("t3_pass", pass, 0);

    // Test 4: every read is inverted, so the 3-bit counter saturates.
    fault = 2;
    start_run(4'd15, 16'h1357);
    wait_done(0, e);
    check("t4_latency", e, 50);
    check("t4_err_sat", err_count, 7);
    check("t4_first", first_err_addr, 0);
    check("t4_pass", pass, 0);

    // Test 6: start arrives in the DONE cycle. The results clear and the new run passes.
    fault = 0;
    start_run(4'd15, 16'h0F0F);
    check("t6_busy", busy, 1);
    check("t6_err_clr", err_count, 0);
    check("t6_pass_clr", pass, 0);
    wait_done(0, e);
    check("t6_latency", e, 50);
    check("t6_pass", pass, 1);
    check("t6_err", err_count, 0);
    check("t6_mem9", mem[9], 16'h0F06);

    // Test 5: a single-word run. A second start while busy must be ignored.
    repeat (3) @(posedge clk);
    #1;
    start_run(4'd0, 16'h1234);
    @(posedge clk);
    #1 start = 1'b1;
    last_addr = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2, e);
    check("t5_latency", e, 5);
    check("t5_pass", pass, 1);
    check("t5_mem0", mem[0], 16'h1234);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_rerun", {busy, done, ce_n}, 3'b001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
